// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: request mode encodings,
// responder state enum and the latched-request record.
package mem_responder_pkg;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } memrstate_t;

    // Request fields captured when a request is accepted in IDLE.
    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memreq_t;

endpackage

// File: rtl/mem_responder_bram.sv
// Single-port 2^ADDR_WIDTH x 32 RAM: one-cycle registered read, per-byte
// write enables, read-before-write. Contents start at zero when the device
// is configured and are never cleared afterwards.
module mem_responder_bram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [3:0]            i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH] = '{default: 32'h0};
    logic [31:0] r_rdata;

    // Registered read of the old word, then byte-lane writes on the same edge.
    // NOTE: the array has no reset branch on purpose; a reset would turn the
    // block RAM into thousands of flops and the contents must survive reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_addr];
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint of the single-outstanding request/response bus.
// A request accepted in IDLE starts the RAM read at once, waits LATENCY
// edges, then pulses response_enable for one cycle with the old word.
// Writes land at the completion edge; out-of-range accesses read as zero
// and drop their write but still respond on time.
// Optional feature macro: MEM_RESPONDER_PERF_CNT_EN (read/write counters).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        request_enable,
    input  logic        req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        response_enable,
    output logic [31:0] resp_data
`ifdef MEM_RESPONDER_PERF_CNT_EN
    ,
    output logic [31:0] read_count,
    output logic [31:0] write_count
`endif
);

    localparam int          LAT      = (LATENCY < 1) ? 1 : LATENCY;
    localparam logic [3:0]  LAT_M1   = 4'(LAT - 1);
    localparam logic [32:0] CAPACITY = 33'(4) << ADDR_WIDTH;

    memrstate_t r_state;
    memrstate_t w_next_state;
    logic [3:0] r_count;
    logic [3:0] w_next_count;
    memreq_t    r_req;
    logic        r_resp_en;
    logic [31:0] r_resp_data;

    logic                  w_accept;
    logic                  w_complete;
    logic [31:0]           w_lat_off;
    logic                  w_lat_in_range;
    logic [ADDR_WIDTH-1:0] w_live_idx;
    logic [ADDR_WIDTH-1:0] w_lat_idx;
    logic [ADDR_WIDTH-1:0] w_bram_addr;
    logic                  w_bram_en;
    logic [3:0]            w_bram_we;
    logic [31:0]           w_bram_rdata;

    assign w_accept   = (r_state == IDLE) && request_enable;
    assign w_complete = (r_state == BUSY) && (r_count == 4'd0);

    // Word index wraps in 32-bit arithmetic; range check uses the latched address.
    assign w_live_idx     = ADDR_WIDTH'((req_addr - BASE_ADDR) >> 2);
    assign w_lat_off      = r_req.addr - BASE_ADDR;
    assign w_lat_idx      = ADDR_WIDTH'(w_lat_off >> 2);
    assign w_lat_in_range = (r_req.addr >= BASE_ADDR) && ({1'b0, w_lat_off} < CAPACITY);

    // The read is issued from the live address on the accept edge; the write
    // uses the latched address on the completion edge. Reset suppresses both,
    // so an unfinished write never reaches the RAM.
    assign w_bram_addr = (r_state == IDLE) ? w_live_idx : w_lat_idx;
    assign w_bram_en   = rstn && (w_accept || w_complete);
    assign w_bram_we   = (rstn && w_complete && (r_req.mode == MEMREQ_WRITE) && w_lat_in_range)
                         ? r_req.wstrb : 4'b0000;

    mem_responder_bram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk     (clk),
        .i_en    (w_bram_en),
        .i_we    (w_bram_we),
        .i_addr  (w_bram_addr),
        .i_wdata (r_req.wdata),
        .o_rdata (w_bram_rdata)
    );

    // Next-state logic: accept in IDLE, count down in BUSY, one cycle in RESPOND.
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        unique case (r_state)
            IDLE: begin
                if (request_enable) begin
                    w_next_state = BUSY;
                    w_next_count = LAT_M1;
                end
            end
            BUSY: begin
                if (r_count == 4'd0) begin
                    w_next_state = RESPOND;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            RESPOND: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, latency counter and latched request.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_req   <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if (w_accept) begin
                r_req <= '{mode: req_mode, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
            end
        end
    end

    // Response pulse and held response data, loaded on the completion edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_resp_en   <= 1'b0;
            r_resp_data <= 32'h0;
        end else begin
            r_resp_en <= w_complete;
            if (w_complete) begin
                r_resp_data <= w_lat_in_range ? w_bram_rdata : 32'h0;
            end
        end
    end

    assign response_enable = r_resp_en;
    assign resp_data       = r_resp_data;

`ifdef MEM_RESPONDER_PERF_CNT_EN
    logic [31:0] r_read_count;
    logic [31:0] r_write_count;

    // Count completed reads and writes, out-of-range accesses included.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_read_count  <= 32'd0;
            r_write_count <= 32'd0;
        end else if (w_complete) begin
            if (r_req.mode == MEMREQ_WRITE) begin
                r_write_count <= r_write_count + 32'd1;
            end else begin
                r_read_count <= r_read_count + 32'd1;
            end
        end
    end

    assign read_count  = r_read_count;
    assign write_count = r_write_count;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances: u0 (LATENCY=1,
// BASE=0) and u1 (LATENCY=3, BASE=0x80000000), both with 16 words.
// A reference model predicts, edge by edge, when each response must appear
// and what it must carry; directed transactions pin the model with literals,
// then a randomized phase runs both instances with resets mixed in.
// Optional feature macro: MEM_RESPONDER_PERF_CNT_EN.
module tb_mem_responder;

    localparam int AW    = 4;
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn      [2];
    logic        req_en    [2];
    logic        req_mode  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_wstrb [2];
    logic        resp_en   [2];
    logic [31:0] resp_data [2];
`ifdef MEM_RESPONDER_PERF_CNT_EN
    logic [31:0] rd_cnt [2];
    logic [31:0] wr_cnt [2];
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .LATENCY(1)) u0 (
        .clk             (clk),
        .rstn            (rstn[0]),
        .request_enable  (req_en[0]),
        .req_mode        (req_mode[0]),
        .req_addr        (req_addr[0]),
        .req_wdata       (req_wdata[0]),
        .req_wstrb       (req_wstrb[0]),
        .response_enable (resp_en[0]),
        .resp_data       (resp_data[0])
`ifdef MEM_RESPONDER_PERF_CNT_EN
        ,
        .read_count      (rd_cnt[0]),
        .write_count     (wr_cnt[0])
`endif
    );

    mem_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u1 (
        .clk             (clk),
        .rstn            (rstn[1]),
        .request_enable  (req_en[1]),
        .req_mode        (req_mode[1]),
        .req_addr        (req_addr[1]),
        .req_wdata       (req_wdata[1]),
        .req_wstrb       (req_wstrb[1]),
        .response_enable (resp_en[1]),
        .resp_data       (resp_data[1])
`ifdef MEM_RESPONDER_PERF_CNT_EN
        ,
        .read_count      (rd_cnt[1]),
        .write_count     (wr_cnt[1])
`endif
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] base_of(input int i);
        return (i == 0) ? 32'h0 : 32'h8000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mem_m [2][WORDS];
    bit          pend      [2];
    longint      resp_edge [2];
    longint      next_acc  [2];
    logic        m_mode    [2];
    logic [31:0] m_addr    [2];
    logic [31:0] m_wdata   [2];
    logic [3:0]  m_wstrb   [2];
    logic        exp_en    [2];
    logic [31:0] exp_data  [2];
    logic [31:0] exp_rc    [2];
    logic [31:0] exp_wc    [2];
    longint      edge_n = 0;

    // Advance the model of instance i by one clock edge using the inputs the
    // DUT sampled at that edge.
    task automatic model_step(input int i);
        logic [31:0] off;
        bit          inr;
        int          idx;
        if (!rstn[i]) begin
            pend[i]     = 1'b0;
            exp_en[i]   = 1'b0;
            exp_data[i] = 32'h0;
            exp_rc[i]   = 32'h0;
            exp_wc[i]   = 32'h0;
            next_acc[i] = edge_n + 1;
        end else begin
            exp_en[i] = 1'b0;
            if (pend[i] && edge_n == resp_edge[i]) begin
                off = m_addr[i] - base_of(i);
                inr = (m_addr[i] >= base_of(i)) && (off < 32'(4 * WORDS));
                idx = int'(off / 4);
                exp_en[i] = 1'b1;
                exp_data[i] = inr ? mem_m[i][idx] : 32'h0;
                if (m_mode[i]) begin
                    exp_wc[i]++;
                    if (inr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (m_wstrb[i][b]) mem_m[i][idx][8*b +: 8] = m_wdata[i][8*b +: 8];
                        end
                    end
                end else begin
                    exp_rc[i]++;
                end
                pend[i] = 1'b0;
            end
            if (req_en[i] && !pend[i] && edge_n >= next_acc[i]) begin
                pend[i]      = 1'b1;
                resp_edge[i] = edge_n + lat_of(i);
                next_acc[i]  = edge_n + lat_of(i) + 2;
                m_mode[i]    = req_mode[i];
                m_addr[i]    = req_addr[i];
                m_wdata[i]   = req_wdata[i];
                m_wstrb[i]   = req_wstrb[i];
            end
        end
    endtask

    // Compare process: just after every rising edge, step the model and
    // check both instances' outputs.
    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < WORDS; w++) mem_m[i][w] = 32'h0;
            pend[i] = 1'b0;
            next_acc[i] = 0;
            exp_en[i] = 1'b0;
            exp_data[i] = 32'h0;
            exp_rc[i] = 32'h0;
            exp_wc[i] = 32'h0;
        end
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            for (int i = 0; i < 2; i++) begin
                model_step(i);
                check($sformatf("u%0d response_enable", i), 32'(resp_en[i]), 32'(exp_en[i]));
                check($sformatf("u%0d resp_data", i), resp_data[i], exp_data[i]);
`ifdef MEM_RESPONDER_PERF_CNT_EN
                check($sformatf("u%0d read_count", i), rd_cnt[i], exp_rc[i]);
                check($sformatf("u%0d write_count", i), wr_cnt[i], exp_wc[i]);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge. Issues one request (held two cycles if dup), waits
    // for the pulse within a bounded budget, then idles one extra cycle so the
    // next request lands in IDLE.
    task automatic do_req(input int i, input logic mode, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input bit dup,
                          output logic [31:0] data, output int lat);
        req_en[i]    = 1'b1;
        req_mode[i]  = mode;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        req_wstrb[i] = wstrb;
        @(negedge clk);
        if (dup) @(negedge clk);
        req_en[i] = 1'b0;
        lat  = -1;
        data = 32'h0;
        for (int n = (dup ? 2 : 1); n <= 40; n++) begin
            @(negedge clk);
            if (resp_en[i]) begin
                lat  = n;
                data = resp_data[i];
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL u%0d response timeout: no pulse within 40 cycles for addr %h", i, addr);
        end
        @(negedge clk);
    endtask

    task automatic rand_phase(input int i);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            req_en[i]    = ($urandom_range(0, 2) == 0);
            req_mode[i]  = 1'($urandom_range(0, 1));
            req_addr[i]  = base_of(i) + 32'($urandom_range(0, 95)) - 32'd16;
            req_wdata[i] = $urandom;
            req_wstrb[i] = 4'($urandom_range(0, 15));
            rstn[i]      = ($urandom_range(0, 60) != 0);
        end
        @(negedge clk);
        req_en[i] = 1'b0;
        rstn[i]   = 1'b1;
    endtask

    logic [31:0] d;
    int          l;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0;
            req_en[i] = 1'b0;
            req_mode[i] = 1'b0;
            req_addr[i] = 32'h0;
            req_wdata[i] = 32'h0;
            req_wstrb[i] = 4'h0;
        end
        repeat (3) @(negedge clk);
        check("reset response_enable", 32'(resp_en[0]), 32'h0);
        check("reset resp_data", resp_data[1], 32'h0);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;

        // LATENCY=1: full write, then readback.
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, d, l);
        check("u0 write pre-data", d, 32'h0);
        check("u0 write latency", 32'(l), 32'd1);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, d, l);
        check("u0 readback", d, 32'hDEAD_BEEF);
        // Byte strobes 0101 over DEADBEEF.
        do_req(0, 1'b1, 32'h12, 32'h1122_3344, 4'b0101, 1'b0, d, l);
        check("u0 strobed write pre-data", d, 32'hDEAD_BEEF);
        do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b0, d, l);
        check("u0 strobed readback", d, 32'hDE22_BE44);
        // Empty strobe: response but no change.
        do_req(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0, d, l);
        check("u0 empty-strobe pre-data", d, 32'hDE22_BE44);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, d, l);
        check("u0 empty-strobe readback", d, 32'hDE22_BE44);

        // LATENCY=3 with BASE=0x80000000; second strobe at E0+1 is ignored.
        do_req(1, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'hF, 1'b0, d, l);
        check("u1 write latency", 32'(l), 32'd3);
        do_req(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b1, d, l);
        check("u1 read with duplicate strobe", d, 32'hCAFE_F00D);
        check("u1 read latency", 32'(l), 32'd3);

        // Out of range below base and one past the top.
        do_req(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0, d, l);
        check("u1 read below base", d, 32'h0);
        check("u1 below-base latency", 32'(l), 32'd3);
        do_req(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b0, d, l);
        check("u1 read past top", d, 32'h0);
        do_req(1, 1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'hF, 1'b0, d, l);
        check("u1 write past top pre-data", d, 32'h0);
        do_req(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, d, l);
        check("u1 word 0 after dropped write", d, 32'h0);
        for (int w = 0; w < WORDS; w++) begin
            do_req(1, 1'b0, 32'h8000_0000 + 32'(4 * w), 32'h0, 4'h0, 1'b0, d, l);
        end

        // Reset at E0+1 cancels a pending write.
        req_en[1]    = 1'b1;
        req_mode[1]  = 1'b1;
        req_addr[1]  = 32'h8000_0004;
        req_wdata[1] = 32'h1234_5678;
        req_wstrb[1] = 4'hF;
        @(negedge clk);
        req_en[1] = 1'b0;
        rstn[1]   = 1'b0;
        @(negedge clk);
        rstn[1] = 1'b1;
        repeat (6) @(negedge clk);
        do_req(1, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 1'b0, d, l);
        check("u1 read after aborted write", d, 32'hCAFE_F00D);

`ifdef MEM_RESPONDER_PERF_CNT_EN
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        do_req(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, d, l);
        do_req(0, 1'b1, 32'h4, 32'h5, 4'hF, 1'b0, d, l);
        do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, d, l);
        do_req(0, 1'b1, 32'h44, 32'h6, 4'hF, 1'b0, d, l);
        do_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, d, l);
        check("u0 read_count", rd_cnt[0], 32'd3);
        check("u0 write_count", wr_cnt[0], 32'd2);
        rstn[0] = 1'b0;
        @(negedge clk);
        check("u0 read_count after reset", rd_cnt[0], 32'd0);
        check("u0 write_count after reset", wr_cnt[0], 32'd0);
        rstn[0] = 1'b1;
`endif

        fork
            rand_phase(0);
            rand_phase(1);
        join
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
